// File: rtl/snes_rom_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : snes_rom_streamer_if
//  Description : Bundles the SNES ROM streamer control, cart-bus and output
//                stream signals.
//                master : the controller/consumer side, plus the cart model
//                         that drives the data bus.
//                slave  : the streamer itself.
//                Signals:
//                  enable, start, map_mode, start_offset, length - control
//                  data, address, rd_n                           - cart bus
//                  out_data, out_valid, out_ready                - byte stream
//                  busy, done                                    - status
//                  checksum  - only when SNES_ROM_STREAMER_CHECKSUM_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
interface snes_rom_streamer_if #(
    parameter int OFFSET_W = 22
);
    logic                enable;
    logic                start;
    logic                map_mode;
    logic [OFFSET_W-1:0] start_offset;
    logic [OFFSET_W-1:0] length;
    logic [7:0]          data;
    logic [23:0]         address;
    logic                rd_n;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                done;
`ifdef SNES_ROM_STREAMER_CHECKSUM_EN
    logic [15:0]         checksum;

    modport master (
        output enable, start, map_mode, start_offset, length, data, out_ready,
        input  address, rd_n, out_data, out_valid, busy, done, checksum
    );
    modport slave (
        input  enable, start, map_mode, start_offset, length, data, out_ready,
        output address, rd_n, out_data, out_valid, busy, done, checksum
    );
`else
    modport master (
        output enable, start, map_mode, start_offset, length, data, out_ready,
        input  address, rd_n, out_data, out_valid, busy, done
    );
    modport slave (
        input  enable, start, map_mode, start_offset, length, data, out_ready,
        output address, rd_n, out_data, out_valid, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/snes_rom_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : snes_rom_streamer
//  Description : Reads a contiguous byte range from an SNES cartridge ROM
//                (LoROM or HiROM mapping), holds each access for
//                ACCESS_CYCLES clocks and streams the bytes out through a
//                small FIFO on a valid/ready interface.
//  Ports       : clk   - master clock
//                rst_n - asynchronous active-low reset
//                bus   - snes_rom_streamer_if.slave (control, cart bus,
//                        output stream, status)
//  Options     : SNES_ROM_STREAMER_CHECKSUM_EN - adds bus.checksum, the
//                16-bit wrap-around sum of the bytes pushed this transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module snes_rom_streamer #(
    parameter int OFFSET_W      = 22,
    parameter int ACCESS_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input wire                 clk,
    input wire                 rst_n,
    snes_rom_streamer_if.slave bus
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [OFFSET_W-1:0] r_offset;
    logic [OFFSET_W-1:0] r_remaining;
    logic                r_map;
    logic [CNT_W-1:0]    r_cnt;
    logic [23:0]         r_address;
    logic                r_rd_n;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W:0]      r_count;

    logic                w_last;
    logic                w_push;
    logic                w_pop;
    logic [PTR_W:0]      w_count_after;
    logic [OFFSET_W-1:0] w_offset_inc;
    logic [OFFSET_W-1:0] w_rem_dec;

    // Linear offset -> cart bus address. LoROM places each 32 KiB chunk in
    // the upper half of banks $80+, HiROM maps linearly into banks $C0+.
    function automatic logic [23:0] f_map(input logic i_hi, input logic [OFFSET_W-1:0] i_off);
        logic [21:0] w_o;
        w_o = 22'(i_off);
        return i_hi ? {2'b11, w_o} : {1'b1, w_o[21:15], 1'b1, w_o[14:0]};
    endfunction

    assign w_last        = (r_state == S_READ) && (r_cnt == CNT_LAST);
    assign w_push        = bus.enable && w_last;
    // Pops are independent of enable so the consumer can drain a frozen engine.
    assign w_pop         = (r_count != '0) && bus.out_ready;
    assign w_count_after = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    assign w_offset_inc  = r_offset + 1'b1;
    assign w_rem_dec     = r_remaining - 1'b1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_last) begin
                    if (w_rem_dec == '0) begin
                        w_next = S_DRAIN;
                    end else if (w_count_after < FIFO_FULL) begin
                        w_next = S_READ;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_count < FIFO_FULL) begin
                    w_next = S_READ;
                end
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Engine registers: everything here freezes while enable is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_offset    <= '0;
            r_remaining <= '0;
            r_map       <= 1'b0;
            r_cnt       <= '0;
            r_address   <= '0;
            r_rd_n      <= 1'b1;
        end else if (bus.enable) begin
            r_state <= w_next;
            r_rd_n  <= (w_next != S_READ);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_offset    <= bus.start_offset;
                        r_remaining <= bus.length;
                        r_map       <= bus.map_mode;
                        r_cnt       <= '0;
                        // A zero-length transfer never touches the bus.
                        if (bus.length != '0) begin
                            r_address <= f_map(bus.map_mode, bus.start_offset);
                        end
                    end
                end
                S_READ: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_offset    <= w_offset_inc;
                        r_remaining <= w_rem_dec;
                        // Back-to-back reads move the address on the same edge;
                        // otherwise the last address stays on the bus.
                        if (w_next == S_READ) begin
                            r_address <= f_map(r_map, w_offset_inc);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_next == S_READ) begin
                        r_cnt     <= '0;
                        r_address <= f_map(r_map, r_offset);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_after;
        end
    end

    // Storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.data;
        end
    end

`ifdef SNES_ROM_STREAMER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (bus.enable && bus.start && (r_state == S_IDLE)) begin
            r_checksum <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum + {8'h00, bus.data};
        end
    end

    assign bus.checksum = r_checksum;
`endif

    assign bus.address   = r_address;
    assign bus.rd_n      = r_rd_n;
    assign bus.out_data  = r_mem[r_rptr];
    assign bus.out_valid = (r_count != '0);
    assign bus.busy      = (r_state != S_IDLE);
    // Gated by enable so a frozen DONE state cannot report completion.
    assign bus.done      = (r_state == S_DONE) && bus.enable;

endmodule
`default_nettype wire

// File: tb/tb_snes_rom_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snes_rom_streamer
//  Description : Self-checking bench for snes_rom_streamer. A reference model
//                lists the addresses and bytes each transfer must produce; a
//                negedge monitor compares bus activity and popped bytes
//                against it every cycle. Directed sequences cover mapping,
//                backpressure, zero length, enable freeze and reset abort.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snes_rom_streamer;

    localparam int OFFSET_W = 22;
    localparam int AC       = 2;
    localparam int DEPTH    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    snes_rom_streamer_if #(.OFFSET_W(OFFSET_W)) bus ();

    snes_rom_streamer #(
        .OFFSET_W      (OFFSET_W),
        .ACCESS_CYCLES (AC),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Cart model: each ROM byte equals the low byte of its offset, which is
    // also the low byte of the mapped bus address.
    assign bus.data = bus.address[7:0];

    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_addr[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  popped[$];
    logic [23:0] read_log[$];
    int          low_cnt    = 0;
    int          reads_done = 0;
    int          done_cnt   = 0;
    int          exp_len    = 0;
    logic [15:0] exp_sum    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    function automatic logic [23:0] map_addr(input bit hi, input int unsigned off);
        int unsigned o;
        o = off % 32'h400000;
        if (hi) return 24'(32'hC00000 + o);
        return 24'(32'h800000 + ((o >> 15) << 16) + 32'h8000 + (o & 32'h7FFF));
    endfunction

    // ------------------------------------------------------------------
    // Monitor: cart-bus addresses, popped bytes and done timing.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd_n == 1'b0) begin
                if ((low_cnt / AC) < exp_addr.size()) begin
                    chk("rd_addr", 32'(bus.address), 32'(exp_addr[low_cnt / AC]));
                end else begin
                    fail_now("rd_extra");
                end
                if (bus.enable) begin
                    low_cnt++;
                    if (low_cnt % AC == 0) begin
                        reads_done++;
                        read_log.push_back(bus.address);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_bytes.size() == 0) begin
                    fail_now("pop_extra");
                end else begin
                    chk("pop_data", 32'(bus.out_data), 32'(exp_bytes.pop_front()));
                    popped.push_back(bus.out_data);
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_when", {30'd0, exp_bytes.size() == 0, low_cnt == exp_len * AC}, 32'd3);
            end
        end
    end

    task automatic clear_model();
        exp_addr.delete();
        exp_bytes.delete();
        popped.delete();
        read_log.delete();
        low_cnt    = 0;
        reads_done = 0;
        exp_len    = 0;
        exp_sum    = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_start(input bit hi, input int unsigned off, input int unsigned len);
        int unsigned o;
        clear_model();
        exp_len = int'(len);
        for (int i = 0; i < int'(len); i++) begin
            o = (off + i) % 32'h400000;
            exp_addr.push_back(map_addr(hi, o));
            exp_bytes.push_back(o[7:0]);
            exp_sum = exp_sum + {8'h00, o[7:0]};
        end
        bus.map_mode     = hi;
        bus.start_offset = OFFSET_W'(off);
        bus.length       = OFFSET_W'(len);
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(done_cnt != d0), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk({name, "_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [23:0] frz_addr;
    int          frz_reads;
    int          d_before;

    initial begin
        bus.enable       = 1'b1;
        bus.start        = 1'b0;
        bus.map_mode     = 1'b0;
        bus.start_offset = '0;
        bus.length       = '0;
        bus.out_ready    = 1'b1;
        cycles(3);
        #1 chk("reset_state", {bus.address, bus.rd_n, bus.busy, bus.out_valid, bus.done},
                              {24'h000000, 1'b1, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;

        // 1: idle after reset release
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", {bus.address, bus.rd_n, bus.busy, bus.out_valid, bus.done},
                        {24'h000000, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk); #1;

        // 2: LoROM bank crossing
        do_start(1'b0, 32'h7FFE, 3);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        wait_done("t2_done", 60);
        chk("t2_reads", read_log.size(), 32'd3);
        if (read_log.size() == 3) begin
            chk("t2_addr0", 32'(read_log[0]), 32'h80FFFE);
            chk("t2_addr1", 32'(read_log[1]), 32'h80FFFF);
            chk("t2_addr2", 32'(read_log[2]), 32'h818000);
        end
        chk("t2_pops", popped.size(), 32'd3);
        if (popped.size() == 3) begin
            chk("t2_byte0", 32'(popped[0]), 32'hFE);
            chk("t2_byte1", 32'(popped[1]), 32'hFF);
            chk("t2_byte2", 32'(popped[2]), 32'h00);
        end
`ifdef SNES_ROM_STREAMER_CHECKSUM_EN
        chk("t2_checksum", 32'(bus.checksum), 32'h01FD);
        chk("t2_checksum_model", 32'(bus.checksum), 32'(exp_sum));
`endif
        chk("t2_idle", {bus.busy, bus.rd_n}, 2'b01);

        // 3: HiROM single byte
        do_start(1'b1, 32'h12345, 1);
        wait_done("t3_done", 40);
        chk("t3_low_cycles", low_cnt, 32'd2);
        if (read_log.size() == 1) chk("t3_addr", 32'(read_log[0]), 32'hC12345);
        else chk("t3_reads", read_log.size(), 32'd1);
        if (popped.size() == 1) chk("t3_byte", 32'(popped[0]), 32'h45);
        else chk("t3_pops", popped.size(), 32'd1);

        // 4: backpressure fills the FIFO, then drains
        bus.out_ready = 1'b0;
        do_start(1'b0, 32'h100, 8);
        cycles(20);
        chk("t4_reads_stalled", reads_done, 32'd4);
        chk("t4_wait", {bus.rd_n, bus.busy, bus.out_valid}, 3'b111);
        bus.out_ready = 1'b1;
        wait_done("t4_done", 100);
        chk("t4_reads", reads_done, 32'd8);
        chk("t4_pops", popped.size(), 32'd8);

        // 5: zero length, then start ignored while busy
        d_before = done_cnt;
        do_start(1'b0, 32'h5, 0);
        @(negedge clk);
        chk("t5_done_pulse", 32'(bus.done), 32'd1);
        cycles(3);
        chk("t5_done_once", 32'(done_cnt - d_before), 32'd1);
        chk("t5_idle", {bus.busy, bus.rd_n}, 2'b01);

        do_start(1'b1, 32'h3FFFFF, 3);
        cycles(2);
        bus.map_mode     = 1'b0;
        bus.start_offset = OFFSET_W'(32'h999);
        bus.length       = OFFSET_W'(5);
        bus.start        = 1'b1;
        cycles(1);
        bus.start = 1'b0;
        wait_done("t5_ignore_done", 60);
        chk("t5_ignore_pops", popped.size(), 32'd3);

        // 6a: enable freeze mid-read
        do_start(1'b0, 32'h4000, 4);
        cycles(1);
        frz_addr  = bus.address;
        frz_reads = reads_done;
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_frozen", {bus.address, bus.rd_n, bus.done}, {frz_addr, 1'b0, 1'b0});
            chk("t6_reads_frozen", reads_done, 32'(frz_reads));
            @(posedge clk); #1;
        end
        bus.enable = 1'b1;
        wait_done("t6_done", 60);
        chk("t6_pops", popped.size(), 32'd4);

        // 6b: reset mid-transfer aborts immediately
        do_start(1'b1, 32'h50, 6);
        cycles(3);
        d_before = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {bus.address, bus.rd_n, bus.busy, bus.out_valid, bus.done},
                                {24'h000000, 1'b1, 1'b0, 1'b0, 1'b0});
        clear_model();
        cycles(3);
        rst_n = 1'b1;
        cycles(6);
        chk("t6_no_done", 32'(done_cnt - d_before), 32'd0);
        chk("t6_after_reset", {bus.address, bus.rd_n, bus.busy, bus.out_valid},
                              {24'h000000, 1'b1, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
